// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg : shared defaults and pushbutton channel indices
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int NUM_KEYS_DEF        = 3;

  localparam int KEY_LEFT    = 0;
  localparam int KEY_NS_WALK = 1;
  localparam int KEY_EW_WALK = 2;

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ----------------------------------------------------------------------------
// key_debouncer : one channel of sync, debounce, press pulse and request latch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic not_reset,
  input  logic i_not_key,
  input  logic i_ack,
  output logic o_key_level,
  output logic o_press_pulse,
  output logic o_pending
);

  localparam int             CW          = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  c_count_max = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_key_level;
  logic          r_press_pulse;
  logic          r_pending;
  logic [CW-1:0] r_count;

  logic w_differ;
  logic w_accept;
  logic w_rise;

  assign w_differ = (r_sync2 != r_key_level);
  assign w_accept = w_differ && (r_count == c_count_max);
  assign w_rise   = w_accept && r_sync2;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_key_level   <= 1'b0;
      r_press_pulse <= 1'b0;
      r_pending     <= 1'b0;
      r_count       <= '0;
    end else begin
      r_sync1 <= ~i_not_key;
      r_sync2 <= r_sync1;
      if (!w_differ || w_accept) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
      if (w_accept) begin
        r_key_level <= r_sync2;
      end
      r_press_pulse <= w_rise;
      // A press accepted on the same edge as an ack keeps the request alive.
      r_pending     <= w_rise | (r_pending & ~i_ack);
    end
  end

  assign o_key_level   = r_key_level;
  assign o_press_pulse = r_press_pulse;
  assign o_pending     = r_pending;

endmodule

`default_nettype wire

// File: rtl/request_conditioner.sv
// ----------------------------------------------------------------------------
// request_conditioner : NUM_KEYS independent pushbutton request channels
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module request_conditioner
  import traffic_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                not_reset,
  input  logic [NUM_KEYS-1:0] not_keys,
  input  logic [NUM_KEYS-1:0] ack,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] pending
);

  generate
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debouncer (
        .clk           (clk),
        .not_reset     (not_reset),
        .i_not_key     (not_keys[g]),
        .i_ack         (ack[g]),
        .o_key_level   (key_level[g]),
        .o_press_pulse (press_pulse[g]),
        .o_pending     (pending[g])
      );
    end
  endgenerate

endmodule

`default_nettype wire
